// File: rtl/fb_scanout_pkg.sv
// Shared definitions for the frame-buffer scanout block.
// Provides frame geometry, FSM state encoding, the stream beat payload and
// a helper that builds a beat from an FB address and its read data.
package fb_scanout_pkg;

    localparam int unsigned FB_W  = 64;
    localparam int unsigned FB_H  = 64;
    localparam int unsigned PIX_W = 12;
    localparam int unsigned FB_AW = 12;
    localparam int unsigned FB_XW = 6;
    localparam int unsigned FB_YW = 6;
    localparam int unsigned FB_N  = FB_W * FB_H;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_e;

    // One pixel-stream beat: PIX_W + 14 bits
    typedef struct packed {
        logic             sof;
        logic             eol;
        logic [FB_YW-1:0] y;
        logic [FB_XW-1:0] x;
        logic [PIX_W-1:0] data;
    } pix_beat_t;

    // Build a beat from a raster address and the pixel read from it
    function automatic pix_beat_t make_beat(input logic [FB_AW-1:0] addr,
                                            input logic [PIX_W-1:0] data);
        pix_beat_t b;
        b.x    = addr[FB_XW-1:0];
        b.y    = addr[FB_AW-1:FB_XW];
        b.data = data;
        b.sof  = (addr == '0);
        b.eol  = (addr[FB_XW-1:0] == FB_XW'(FB_W - 1));
        return b;
    endfunction

endpackage

// File: rtl/fb_skid_fifo.sv
// Small output skid FIFO for the scanout pixel stream.
// Ports: clk/reset (async, active-high), push/wdata write side,
// pop/rdata read side (rdata is the head entry), count = occupancy,
// empty = registered empty flag. Push into a full FIFO is only legal
// together with a pop; the caller guarantees this.
module fb_skid_fifo
    import fb_scanout_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  pix_beat_t                      wdata,
    input  logic                           pop,
    output pix_beat_t                      rdata,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    pix_beat_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            empty_q;

    // Pointer advance with wrap for non-power-of-2 depths
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Next occupancy
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array carries no reset; validity is tracked by count/empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            count_q <= count_d;
            empty_q <= (count_d == '0);
        end
    end

    assign rdata = mem[rd_ptr];
    assign count = count_q;
    assign empty = empty_q;

endmodule

// File: rtl/fb_scanout.sv
// Frame-buffer scanout: after the sprite engine pulses done, reads all
// FB_W*FB_H pixels in raster order from the FB SRAM and streams them out
// as valid/ready beats tagged with x/y and sof/eol markers.
// Ports: clk, reset (async, active-high), done (start pulse);
// FB_CEN/FB_WEN/FB_A/FB_Q SRAM read port; pix_valid/pix_ready handshake
// with pix_data/pix_x/pix_y/pix_sof/pix_eol payload; busy, frame_done status.
module fb_scanout
    import fb_scanout_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 done,
    output logic                 FB_CEN,
    output logic                 FB_WEN,
    output logic [FB_AW-1:0]     FB_A,
    input  logic [PIX_W-1:0]     FB_Q,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic [PIX_W-1:0]     pix_data,
    output logic [FB_XW-1:0]     pix_x,
    output logic [FB_YW-1:0]     pix_y,
    output logic                 pix_sof,
    output logic                 pix_eol,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    state_e            state_q;
    state_e            state_d;
    logic [FB_AW-1:0]  rd_addr_q;
    logic [FB_AW-1:0]  rd_addr_d;
    logic [FB_AW-1:0]  issue_addr;
    logic              issue;
    logic              inflight_q;
    logic              busy_d;
    logic              frame_done_d;
    logic              push;
    logic              pop;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    pix_beat_t         head;
    logic [CW:0]       level_after;

    // Read data arrives at the edge closing the CEN-low cycle; FB_A still
    // holds the issued address then, so it doubles as the x/y tag.
    assign push = inflight_q;
    assign pop  = !fifo_empty && pix_ready;

    // FIFO occupancy after this edge; an issue is allowed only if the
    // resulting read still has a guaranteed slot.
    assign level_after = (CW+1)'(fifo_count) + (CW+1)'(push) - (CW+1)'(pop);

    // Next-state and issue logic
    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        issue        = 1'b0;
        issue_addr   = rd_addr_q;
        busy_d       = busy;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                // Address 0 is issued on the accepting edge to save a cycle
                if (done) begin
                    issue      = 1'b1;
                    issue_addr = '0;
                    rd_addr_d  = FB_AW'(1);
                    busy_d     = 1'b1;
                    state_d    = READ;
                end
            end
            READ: begin
                if (level_after < (CW+1)'(FIFO_DEPTH)) begin
                    issue     = 1'b1;
                    rd_addr_d = rd_addr_q + FB_AW'(1);
                    if (rd_addr_q == FB_AW'(FB_N - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Last beat leaves on this edge: pulse frame_done next cycle
                if (level_after == '0) begin
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered SRAM/status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rd_addr_q  <= '0;
            inflight_q <= 1'b0;
            FB_CEN     <= 1'b1;
            FB_A       <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            inflight_q <= issue;
            FB_CEN     <= !issue;
            if (issue) begin
                FB_A <= issue_addr;
            end
            busy       <= busy_d;
            frame_done <= frame_done_d;
        end
    end

    assign FB_WEN = 1'b1;

    fb_skid_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (make_beat(FB_A, FB_Q)),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign pix_valid = !fifo_empty;
    assign pix_data  = head.data;
    assign pix_x     = head.x;
    assign pix_y     = head.y;
    assign pix_sof   = head.sof;
    assign pix_eol   = head.eol;

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout: stimulus pushes expected beats into a
// queue, a negedge monitor pops and compares on every handshake.
module tb_fb_scanout;

    typedef struct packed {
        logic [11:0] data;
        logic [5:0]  x;
        logic [5:0]  y;
        logic        sof;
        logic        eol;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        done = 1'b0;
    logic        FB_CEN, FB_WEN;
    logic [11:0] FB_A;
    logic [11:0] FB_Q;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic [11:0] pix_data;
    logic [5:0]  pix_x, pix_y;
    logic        pix_sof, pix_eol;
    logic        busy, frame_done;

    logic [11:0] fb_mem [4096];
    beat_t       exp_q [$];

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;     // 0: always 1, 1: held 0, 2: random, 3: toggle
    int beat_cnt = 0, sof_cnt = 0, eol_cnt = 0, fd_count = 0;
    int cyc = 0, first_cyc = 0, last_cyc = 0;
    logic  fd_expect = 1'b0;
    logic  hold_valid = 1'b0;
    beat_t held;

    always #5 clk = ~clk;

    // Combinational SRAM model; junk when not enabled so stray captures show
    assign FB_Q = FB_CEN ? 12'hEAD : fb_mem[FB_A];

    fb_scanout dut (
        .clk        (clk),
        .reset      (reset),
        .done       (done),
        .FB_CEN     (FB_CEN),
        .FB_WEN     (FB_WEN),
        .FB_A       (FB_A),
        .FB_Q       (FB_Q),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_sof    (pix_sof),
        .pix_eol    (pix_eol),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic beat_t exp_beat(input int a);
        beat_t b;
        logic [11:0] av;
        av     = 12'(a);
        b.data = fb_mem[a];
        b.x    = av[5:0];
        b.y    = av[11:6];
        b.sof  = (a == 0);
        b.eol  = (av[5:0] == 6'd63);
        return b;
    endfunction

    always @(posedge clk) cyc++;

    // pix_ready driver
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = 1'b0;
            2:       pix_ready = 1'($urandom_range(0, 1));
            default: pix_ready = !pix_ready;
        endcase
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (reset) begin
            hold_valid = 1'b0;
            fd_expect  = 1'b0;
        end else begin
            if (fd_expect) begin
                check("frame_done_after_last", 32'(frame_done), 32'd1);
                fd_expect = 1'b0;
            end else if (frame_done) begin
                checks++;
                errors++;
                $display("FAIL frame_done_spurious: got 1 expected 0 (t=%0t)", $time);
            end
            if (frame_done) fd_count++;
            if (hold_valid) begin
                check("stable_valid", 32'(pix_valid), 32'd1);
                check("stable_beat", 32'({pix_data, pix_x, pix_y, pix_sof, pix_eol}), 32'(held));
            end
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got x=%0d y=%0d expected none", pix_x, pix_y);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat", 32'({pix_data, pix_x, pix_y, pix_sof, pix_eol}), 32'(e));
                end
                if (beat_cnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                beat_cnt++;
                if (pix_sof) sof_cnt++;
                if (pix_eol) eol_cnt++;
                if (pix_x == 6'd63 && pix_y == 6'd63) fd_expect = 1'b1;
            end
            hold_valid = pix_valid && !pix_ready;
            held = {pix_data, pix_x, pix_y, pix_sof, pix_eol};
        end
    end

    // Queue the expected frame, then pulse done; returns inside cycle T+1
    task automatic start_frame();
        beat_cnt = 0;
        sof_cnt  = 0;
        eol_cnt  = 0;
        for (int a = 0; a < 4096; a++) exp_q.push_back(exp_beat(a));
        @(posedge clk);
        #1 done = 1'b1;
        @(posedge clk);
        #1 done = 1'b0;
    endtask

    task automatic wait_frame();
        int start;
        start = fd_count;
        for (int i = 0; i < 20000 && fd_count == start; i++) @(negedge clk);
        if (fd_count == start) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got no frame_done expected one");
        end
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 20000 && beat_cnt < n; i++) @(posedge clk);
        #1;
        check("beats_reached", 32'(beat_cnt >= n), 32'd1);
    endtask

    initial begin
        int reads;
        int fd0;
        logic [11:0] ra [2];

        for (int a = 0; a < 4096; a++) fb_mem[a] = 12'((a * 37 + 5) ^ (a >> 3));

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cen", 32'(FB_CEN), 32'd1);
        check("rst_wen", 32'(FB_WEN), 32'd1);
        check("rst_a", 32'(FB_A), 32'd0);
        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);

        // 1: full-rate frame, latency and back-to-back beats
        ready_mode = 0;
        start_frame();
        @(negedge clk);
        check("t1_cen_low", 32'(FB_CEN), 32'd0);
        check("t1_a0", 32'(FB_A), 32'd0);
        check("t1_valid_t1", 32'(pix_valid), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_valid_t2", 32'(pix_valid), 32'd1);
        wait_frame();
        check("t1_beats", 32'(beat_cnt), 32'd4096);
        check("t1_span", 32'(last_cyc - first_cyc), 32'd4095);
        check("t1_wen", 32'(FB_WEN), 32'd1);

        // 2: ready held low: only two reads issued
        ready_mode = 1;
        pix_ready  = 1'b0;
        start_frame();
        reads = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!FB_CEN) begin
                if (reads < 2) ra[reads] = FB_A;
                reads++;
            end
        end
        check("t2_reads", 32'(reads), 32'd2);
        check("t2_a0", 32'(ra[0]), 32'd0);
        check("t2_a1", 32'(ra[1]), 32'd1);
        check("t2_cen_idle", 32'(FB_CEN), 32'd1);
        check("t2_valid", 32'(pix_valid), 32'd1);
        check("t2_data", 32'(pix_data), 32'(fb_mem[0]));
        ready_mode = 0;
        wait_frame();

        // 3: random backpressure
        ready_mode = 2;
        start_frame();
        wait_frame();
        check("t3_beats", 32'(beat_cnt), 32'd4096);
        check("t3_sof", 32'(sof_cnt), 32'd1);
        check("t3_eol", 32'(eol_cnt), 32'd64);

        // 4: second done while busy is ignored
        ready_mode = 0;
        fd0 = fd_count;
        start_frame();
        wait_beats(100);
        done = 1'b1;
        @(posedge clk);
        #1 done = 1'b0;
        wait_frame();
        repeat (20) @(negedge clk);
        check("t4_one_fd", 32'(fd_count - fd0), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_cen", 32'(FB_CEN), 32'd1);
        check("t4_beats", 32'(beat_cnt), 32'd4096);

        // 5: reset mid-frame, then a fresh frame
        ready_mode = 2;
        start_frame();
        wait_beats(2000);
        reset = 1'b1;
        #1;
        check("t5_valid", 32'(pix_valid), 32'd0);
        check("t5_cen", 32'(FB_CEN), 32'd1);
        check("t5_a", 32'(FB_A), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_fd", 32'(frame_done), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        ready_mode = 0;
        start_frame();
        @(negedge clk);
        check("t5_restart_a", 32'(FB_A), 32'd0);
        check("t5_restart_cen", 32'(FB_CEN), 32'd0);
        @(negedge clk);
        check("t5_sof", 32'(pix_sof), 32'd1);
        wait_frame();
        check("t5_beats", 32'(beat_cnt), 32'd4096);

        // 6: checkerboard with toggling ready
        for (int a = 0; a < 4096; a++) fb_mem[a] = (((a ^ (a >> 6)) & 1) != 0) ? 12'hFFF : 12'h000;
        ready_mode = 3;
        start_frame();
        wait_frame();
        check("t6_beats", 32'(beat_cnt), 32'd4096);
        check("t6_eol", 32'(eol_cnt), 32'd64);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
